// File: rtl/noc_parameters_pkg.sv
// Shared definitions for the NoC router input port: flit encoding,
// output-port numbering, mesh coordinate width and input FSM states.
package noc_parameters;

  // Mesh coordinates are 4 bits per axis.
  localparam int COORD_W = 4;

  // Flit type lives in the two most significant bits of every flit.
  typedef enum logic [1:0] {
    FLIT_BODY   = 2'b00,
    FLIT_HEAD   = 2'b01,
    FLIT_TAIL   = 2'b10,
    FLIT_SINGLE = 2'b11
  } flit_type_t;

  // Router output-port indices; request/grant/free bit positions.
  localparam int PORT_LOCAL = 0;
  localparam int PORT_NORTH = 1;
  localparam int PORT_SOUTH = 2;
  localparam int PORT_EAST  = 3;
  localparam int PORT_WEST  = 4;

  // Input-port packet FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // True for flits that open a packet.
  function automatic logic is_start_type(input flit_type_t t);
    return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
  endfunction

  // True for flits that close a packet.
  function automatic logic is_last_type(input flit_type_t t);
    return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Flit buffer for one router input. Circular buffer with power-of-two
// depth; a pushed flit is readable at the head on the following cycle.
// Storage is not reset, only pointers and the occupancy count.
module noc_flit_fifo #(
  parameter int DEPTH      = 4,
  parameter int FLIT_WIDTH = 32
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [FLIT_WIDTH-1:0] wdata,
  output logic [FLIT_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [FLIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; no reset needed since count gates visibility.
  always_ff @(posedge noc_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally at DEPTH; simultaneous push/pop keeps count.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_input_port.sv
// One router input port: buffers incoming flits, computes the XY route
// from each head flit, requests the output arbiter and streams the
// packet to the crossbar once granted. Stray body/tail flits that show
// up without a head are discarded with a one-cycle drop pulse.
//
// Handshakes: a transfer happens in any cycle where valid and ready are
// both high at the rising edge. valid never depends on ready; ready may
// be asserted without valid. in_ready reflects only buffer space.
module noc_input_port
  import noc_parameters::*;
#(
  parameter int DEPTH      = 4,
  parameter int FLIT_WIDTH = 32,
  parameter int PORTS      = 5,
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLIT_WIDTH-1:0] in_flit,
  output logic [PORTS-1:0]      request,
  input  logic [PORTS-1:0]      grant,
  output logic [PORTS-1:0]      free,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  drop,
  output state_t                fsm_state
);

  localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_ID);
  localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_ID);

  // Dimension-ordered routing: resolve X first, then Y, else eject.
  function automatic logic [PORTS-1:0] route_xy(input logic [COORD_W-1:0] dx,
                                                input logic [COORD_W-1:0] dy);
    logic [PORTS-1:0] r;
    r = '0;
    if (dx > MY_X)      r[PORT_EAST]  = 1'b1;
    else if (dx < MY_X) r[PORT_WEST]  = 1'b1;
    else if (dy > MY_Y) r[PORT_NORTH] = 1'b1;
    else if (dy < MY_Y) r[PORT_SOUTH] = 1'b1;
    else                r[PORT_LOCAL] = 1'b1;
    return r;
  endfunction

  state_t                state;
  logic [PORTS-1:0]      route_q;
  logic [FLIT_WIDTH-1:0] head_flit;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  flit_type_t            head_type;
  logic                  head_start;
  logic                  head_last;
  logic                  xfer;

  noc_flit_fifo #(
    .DEPTH      (DEPTH),
    .FLIT_WIDTH (FLIT_WIDTH)
  ) u_fifo (
    .noc_clk (noc_clk),
    .noc_rst (noc_rst),
    .push    (in_valid),
    .pop     (fifo_pop),
    .wdata   (in_flit),
    .rdata   (head_flit),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Head-of-buffer decode and handshake outputs.
  always_comb begin
    head_type  = flit_type_t'(head_flit[FLIT_WIDTH-1:FLIT_WIDTH-2]);
    head_start = is_start_type(head_type);
    head_last  = is_last_type(head_type);
    in_ready   = !fifo_full;
    out_flit   = head_flit;
    out_valid  = (state == ST_XFER) && !fifo_empty;
    xfer       = out_valid && out_ready;
    request    = (state == ST_IDLE) ? '0 : route_q;
    // A stray flit is discarded straight out of IDLE; never during reset.
    drop       = (state == ST_IDLE) && !fifo_empty && !head_start && !noc_rst;
    // Release the output only when the closing flit actually moves.
    free       = (xfer && head_last && !noc_rst) ? request : '0;
    fifo_pop   = xfer || drop;
    fsm_state  = state;
  end

  // Packet FSM: latch route on a head, wait for grant, stream to the tail.
  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state   <= ST_IDLE;
      route_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && head_start) begin
            route_q <= route_xy(head_flit[7:4], head_flit[3:0]);
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (|(grant & request)) state <= ST_XFER;
        end
        ST_XFER: begin
          if (xfer && head_last) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_input_port.sv
// Bench for noc_input_port with X_ID=1, Y_ID=1, DEPTH=4.
module tb_noc_input_port;
  import noc_parameters::*;

  localparam int DEPTH = 4;
  localparam int FW    = 32;
  localparam int PORTS = 5;
  localparam int X_ID  = 1;
  localparam int Y_ID  = 1;
  // Expected event: {is_drop, is_last, route, flit}
  localparam int EW    = 2 + PORTS + FW;

  // ---------------- clock / reset ----------------
  logic             noc_clk = 1'b0;
  logic             noc_rst;
  logic             in_valid;
  logic             in_ready;
  logic [FW-1:0]    in_flit;
  logic [PORTS-1:0] request;
  logic [PORTS-1:0] grant;
  logic [PORTS-1:0] free;
  logic             out_valid;
  logic             out_ready;
  logic [FW-1:0]    out_flit;
  logic             drop;
  state_t           fsm_state;

  always #5 noc_clk = ~noc_clk;

  noc_input_port #(
    .DEPTH      (DEPTH),
    .FLIT_WIDTH (FW),
    .PORTS      (PORTS),
    .X_ID       (X_ID),
    .Y_ID       (Y_ID)
  ) dut (
    .noc_clk   (noc_clk),
    .noc_rst   (noc_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flit   (in_flit),
    .request   (request),
    .grant     (grant),
    .free      (free),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flit  (out_flit),
    .drop      (drop),
    .fsm_state (fsm_state)
  );

  // ---------------- bookkeeping ----------------
  int n_vec    = 0;
  int n_err    = 0;
  int xfer_cnt = 0;
  int drop_cnt = 0;
  int free_cnt = 0;

  logic [EW-1:0]    exp_q[$];
  logic [FW-1:0]    src_q[$];
  bit               in_pkt = 1'b0;
  logic [PORTS-1:0] cur_route = '0;
  logic [EW-1:0]    mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    n_err++;
    $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [PORTS-1:0] ref_route(input int dx, input int dy);
    logic [PORTS-1:0] one;
    one = PORTS'(1);
    if (dx > X_ID) return one << PORT_EAST;
    if (dx < X_ID) return one << PORT_WEST;
    if (dy > Y_ID) return one << PORT_NORTH;
    if (dy < Y_ID) return one << PORT_SOUTH;
    return one << PORT_LOCAL;
  endfunction

  function automatic logic [FW-1:0] mk_flit(input logic [1:0] t, input logic [3:0] dx,
                                            input logic [3:0] dy, input logic [21:0] pay);
    return {t, pay, dx, dy};
  endfunction

  // Packet-level view: stray flits outside a packet are dropped, every
  // other flit is delivered on the route chosen by its packet's head.
  function automatic void model_push(input logic [FW-1:0] f);
    logic [1:0] t;
    logic       last;
    t = f[FW-1:FW-2];
    if (!in_pkt) begin
      if (t == 2'b01 || t == 2'b11) begin
        cur_route = ref_route(int'(f[7:4]), int'(f[3:0]));
        exp_q.push_back({1'b0, (t == 2'b11), cur_route, f});
        in_pkt = (t == 2'b01);
      end else begin
        exp_q.push_back({1'b1, 1'b0, {PORTS{1'b0}}, f});
      end
    end else begin
      last = (t == 2'b10 || t == 2'b11);
      exp_q.push_back({1'b0, last, cur_route, f});
      in_pkt = !last;
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge noc_clk) begin
    if (noc_rst) begin
      check("free_in_reset", free, 0);
    end else begin
      if (|free) free_cnt++;
      if (drop) begin
        drop_cnt++;
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_drop", drop, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("drop_kind", mon_e[EW-1], 1);
        end
      end
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          flag_fail("unexpected_out", out_flit, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_kind", mon_e[EW-1], 0);
          check("out_flit", out_flit, mon_e[FW-1:0]);
          check("out_request", request, mon_e[FW+PORTS-1:FW]);
          check("free_on_xfer", free, mon_e[EW-2] ? mon_e[FW+PORTS-1:FW] : '0);
        end
      end else begin
        check("free_idle", free, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    if (src_q.size() > 0) begin
      in_valid = 1'b1;
      in_flit  = src_q[0];
      if (in_ready) begin
        model_push(src_q[0]);
        void'(src_q.pop_front());
      end
    end else begin
      in_valid = 1'b0;
    end
    @(posedge noc_clk);
    #1;
  endtask

  task automatic do_reset();
    noc_rst   = 1'b1;
    in_valid  = 1'b0;
    grant     = '0;
    out_ready = 1'b0;
    src_q.delete();
    exp_q.delete();
    in_pkt    = 1'b0;
    @(posedge noc_clk);
    #1;
    noc_rst   = 1'b0;
  endtask

  // mode 0: hold grant/out_ready, 1: toggle out_ready, 2: randomize both
  task automatic drain(input int mode, input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || fsm_state != ST_IDLE) && n < budget) begin
      if (mode == 1) out_ready = !out_ready;
      if (mode == 2) begin
        grant     = PORTS'($urandom_range(0, 31));
        out_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      n++;
    end
    if (n >= budget) flag_fail("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_request(input int budget, input bit toggle);
    int n;
    n = 0;
    while (request == '0 && n < budget) begin
      if (toggle) out_ready = !out_ready;
      step();
      n++;
    end
  endtask

  task automatic gen_packet();
    int r;
    int nb;
    logic [3:0] dx;
    logic [3:0] dy;
    r  = $urandom_range(0, 7);
    dx = 4'($urandom_range(0, 3));
    dy = 4'($urandom_range(0, 3));
    if (r == 0) begin
      src_q.push_back(mk_flit(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                              4'($urandom), 4'($urandom), 22'($urandom)));
    end else if (r < 3) begin
      src_q.push_back(mk_flit(2'b11, dx, dy, 22'($urandom)));
    end else begin
      nb = $urandom_range(0, 2);
      src_q.push_back(mk_flit(2'b01, dx, dy, 22'($urandom)));
      for (int i = 0; i < nb; i++) src_q.push_back({2'b00, 30'($urandom)});
      src_q.push_back({2'b10, 30'($urandom)});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int x0;
    int f0;
    int d0;
    int n;
    noc_rst   = 1'b1;
    in_valid  = 1'b0;
    in_flit   = '0;
    grant     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge noc_clk);
    #1;
    do_reset();

    // Reset state after idling
    repeat (5) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_request", request, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_free", free, 0);
    check("rst_drop", drop, 0);
    check("rst_state", fsm_state, ST_IDLE);

    // Single flit to (3,1): east, grant already present
    do_reset();
    grant = 5'b01000;
    out_ready = 1'b1;
    f0 = free_cnt;
    src_q.push_back(mk_flit(2'b11, 4'd3, 4'd1, 22'h12345));
    wait_request(20, 1'b0);
    check("single_request", request, 5'b01000);
    step();
    check("single_out_valid", out_valid, 1);
    drain(0, 50);
    check("single_free_pulses", free_cnt - f0, 1);

    // Four-flit packet to (1,0): south, grant delayed, out_ready toggling
    do_reset();
    x0 = xfer_cnt;
    f0 = free_cnt;
    src_q.push_back(mk_flit(2'b01, 4'd1, 4'd0, 22'h0aaaa));
    src_q.push_back({2'b00, 30'h0badcafe});
    src_q.push_back({2'b00, 30'h01234567});
    src_q.push_back({2'b10, 30'h3eadbeef});
    wait_request(20, 1'b1);
    check("pkt_request", request, 5'b00100);
    for (int i = 0; i < 4; i++) begin
      out_ready = !out_ready;
      step();
      check("pkt_request_held", request, 5'b00100);
    end
    grant = 5'b00100;
    drain(1, 100);
    check("pkt_flits", xfer_cnt - x0, 4);
    check("pkt_free_pulses", free_cnt - f0, 1);

    // Buffer full: four pushes with no grant, fifth held until a pop
    do_reset();
    x0 = xfer_cnt;
    src_q.push_back(mk_flit(2'b01, 4'd2, 4'd1, 22'h00001));
    src_q.push_back({2'b00, 30'h00000002});
    src_q.push_back({2'b00, 30'h00000003});
    src_q.push_back({2'b00, 30'h00000004});
    repeat (4) step();
    check("full_in_ready", in_ready, 0);
    src_q.push_back({2'b10, 30'h00000005});
    for (int i = 0; i < 3; i++) begin
      step();
      check("full_held_ready", in_ready, 0);
      check("full_held_pending", src_q.size(), 1);
    end
    grant = 5'b01000;
    out_ready = 1'b1;
    drain(0, 100);
    check("full_flits", xfer_cnt - x0, 5);

    // Stray body and tail flits dropped, then a local single delivered
    do_reset();
    grant = 5'b00001;
    out_ready = 1'b1;
    x0 = xfer_cnt;
    d0 = drop_cnt;
    src_q.push_back({2'b00, 30'h1111_0000});
    src_q.push_back({2'b10, 30'h2222_0000});
    src_q.push_back(mk_flit(2'b11, 4'd1, 4'd1, 22'h3c3c3));
    drain(0, 50);
    check("stray_drops", drop_cnt - d0, 2);
    check("stray_flits_out", xfer_cnt - x0, 1);

    // Reset after two of four flits have left
    do_reset();
    grant = 5'b10000;
    out_ready = 1'b1;
    x0 = xfer_cnt;
    src_q.push_back(mk_flit(2'b01, 4'd0, 4'd2, 22'h00777));
    src_q.push_back({2'b00, 30'h0000_0aaa});
    src_q.push_back({2'b00, 30'h0000_0bbb});
    src_q.push_back({2'b10, 30'h0000_0ccc});
    n = 0;
    while (xfer_cnt - x0 < 2 && n < 30) begin
      step();
      n++;
    end
    check("mid_rst_xfers", xfer_cnt - x0, 2);
    f0 = free_cnt;
    do_reset();
    check("mid_rst_state", fsm_state, ST_IDLE);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_request", request, 0);
    check("mid_rst_free", free, 0);
    grant = 5'b10000;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_out_valid", out_valid, 0);
      check("post_rst_drop", drop, 0);
    end
    check("mid_rst_no_free", free_cnt - f0, 0);

    // Random traffic against the packet-level model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (src_q.size() < 3) gen_packet();
      grant     = PORTS'($urandom_range(0, 31));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(2, 3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
